// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port (CPU / front panel) RAM arbiter:
// FSM state encoding, owner constants, default widths and counter sizing.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_PNL = 1'b1;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_HOLD_MAX = 4;

  // The starvation counter is never narrower than 3 bits so HOLD_MAX up to 7 fits.
  function automatic int hold_cnt_w(input int hold_max);
    int w;
    w = $clog2(hold_max + 1);
    return (w < 3) ? 3 : w;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of requester handshakes, shared read data, RAM port and status for mem_arbiter.
// The arbiter connects through the slave modport; requesters and the RAM drive the master side.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arbiter_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_arbiter_pkg::DEF_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;

  logic              pnl_req;
  logic              pnl_we;
  logic [ADDR_W-1:0] pnl_addr;
  logic [DATA_W-1:0] pnl_wdata;
  logic              pnl_gnt;
  logic              pnl_rvalid;

  logic [DATA_W-1:0] rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_read;
  logic              ram_write;
  logic [DATA_W-1:0] ram_rdata;

  logic              owner;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  pnl_req, pnl_we, pnl_addr, pnl_wdata,
    input  ram_rdata,
    output cpu_gnt, cpu_rvalid, pnl_gnt, pnl_rvalid, rdata,
    output ram_addr, ram_wdata, ram_read, ram_write,
    output owner, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output pnl_req, pnl_we, pnl_addr, pnl_wdata,
    output ram_rdata,
    input  cpu_gnt, cpu_rvalid, pnl_gnt, pnl_rvalid, rdata,
    input  ram_addr, ram_wdata, ram_read, ram_write,
    input  owner, busy
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Winner selection for mem_arbiter: fixed CPU priority with a panel starvation limit,
// or round-robin when MEM_ARB_RR_EN is defined.
module arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic cpu_req,
  input  logic pnl_req,
  input  logic decide,
  output logic pick_pnl
);

`ifdef MEM_ARB_RR_EN

  logic last_cpu;

  always_comb begin
    pick_pnl = pnl_req && (!cpu_req || last_cpu);
  end

  // Clearing last_cpu on reset lets the CPU win the first contested decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_cpu <= 1'b0;
    end else if (decide) begin
      last_cpu <= !pick_pnl;
    end
  end

`else

  localparam int              CNT_W    = hold_cnt_w(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);

  logic [CNT_W-1:0] hold_cnt;

  always_comb begin
    pick_pnl = pnl_req && (!cpu_req || (hold_cnt >= HOLD_LIM));
  end

  // Counts CPU wins the panel had to sit through; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (decide) begin
      if (!pnl_req || pick_pnl) begin
        hold_cnt <= '0;
      end else if (hold_cnt != {CNT_W{1'b1}}) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port RAM between CPU and front panel; one access per grant.
// Define MEM_ARB_RR_EN for round-robin instead of CPU priority with starvation limit.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int HOLD_MAX = DEF_HOLD_MAX
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  arb_state_e state;
  arb_state_e state_nxt;

  logic              any_req;
  logic              decide;
  logic              take;
  logic              pick_pnl;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_read_q;
  logic              ram_write_q;
  logic              cpu_gnt_q;
  logic              pnl_gnt_q;
  logic              cpu_rvalid_q;
  logic              pnl_rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              owner_q;

  arb_pick #(
    .HOLD_MAX (HOLD_MAX)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (bus.cpu_req),
    .pnl_req  (bus.pnl_req),
    .decide   (take),
    .pick_pnl (pick_pnl)
  );

  // IDLE and RESP are the decision points; a decision needs at least one live request.
  always_comb begin
    any_req   = bus.cpu_req || bus.pnl_req;
    decide    = (state == IDLE) || (state == RESP);
    take      = decide && any_req;
    win_we    = pick_pnl ? bus.pnl_we    : bus.cpu_we;
    win_addr  = pick_pnl ? bus.pnl_addr  : bus.cpu_addr;
    win_wdata = pick_pnl ? bus.pnl_wdata : bus.cpu_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = any_req ? ACCESS : IDLE;
      ACCESS:  state_nxt = ram_write_q ? IDLE : RESP;
      RESP:    state_nxt = any_req ? ACCESS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes, grants and rvalid are single-cycle pulses; address/data/owner hold until the next decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_read_q   <= 1'b0;
      ram_write_q  <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      pnl_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      pnl_rvalid_q <= 1'b0;
      rdata_q      <= '0;
      owner_q      <= OWN_CPU;
    end else begin
      ram_read_q   <= 1'b0;
      ram_write_q  <= 1'b0;
      cpu_gnt_q    <= 1'b0;
      pnl_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      pnl_rvalid_q <= 1'b0;
      if (state == RESP) begin
        rdata_q <= bus.ram_rdata;
        if (owner_q == OWN_CPU) begin
          cpu_rvalid_q <= 1'b1;
        end else begin
          pnl_rvalid_q <= 1'b1;
        end
      end
      if (take) begin
        owner_q     <= pick_pnl ? OWN_PNL : OWN_CPU;
        ram_addr_q  <= win_addr;
        ram_wdata_q <= win_wdata;
        ram_write_q <= win_we;
        ram_read_q  <= !win_we;
        cpu_gnt_q   <= !pick_pnl;
        pnl_gnt_q   <= pick_pnl;
      end
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.ram_read   = ram_read_q;
  assign bus.ram_write  = ram_write_q;
  assign bus.cpu_gnt    = cpu_gnt_q;
  assign bus.pnl_gnt    = pnl_gnt_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.pnl_rvalid = pnl_rvalid_q;
  assign bus.rdata      = rdata_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = (state != IDLE);

endmodule
